// File: rtl/fetch_controller.sv
// Fetch controller: owns the PC, reads the combinational I-cache and buffers
// {pc, instr} pairs in a small circular queue that feeds decode.
module fetch_controller #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_WORDS = 552
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] icache_addr,
    input  logic [31:0] icache_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        halted
);

    localparam int unsigned PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W     = PTR_W + 1;
    localparam logic [31:0] LAST_PC   = 32'((MEM_WORDS - 1) * 4);
    localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    logic [0:0]       state;
    logic [0:0]       state_nxt;
    logic [31:0]      pc;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic [31:0]      q_pc    [DEPTH];
    logic [31:0]      q_instr [DEPTH];

    logic        pop_c;
    logic        fetch_c;
    logic        pc_ok_c;
    logic        at_last_c;
    logic [31:0] redirect_target_c;

    // Handshake and fetch qualification; a full queue may still fetch when it pops.
    always_comb begin
        redirect_target_c = redirect_pc & 32'hFFFF_FFFC;
        pc_ok_c           = (pc < MEM_BYTES);
        at_last_c         = (pc == LAST_PC);
        pop_c             = out_valid & out_ready;
        fetch_c           = (state == ST_RUN) & ~redirect_valid & pc_ok_c &
                            ((count < FULL) | pop_c);
    end

    // Next state: redirect restarts fetch; running off the end of memory halts.
    always_comb begin
        state_nxt = state;
        if (redirect_valid) begin
            state_nxt = ST_RUN;
        end else if (state == ST_RUN) begin
            if (!pc_ok_c) begin
                state_nxt = ST_HALT;
            end else if (fetch_c && at_last_c) begin
                state_nxt = ST_HALT;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // PC, queue pointers and occupancy; a redirect flushes everything.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc    <= RESET_PC;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (redirect_valid) begin
            pc    <= redirect_target_c;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (fetch_c) begin
                tail <= tail + PTR_W'(1);
                if (!at_last_c) begin
                    pc <= pc + 32'd4;
                end
            end
            if (pop_c) begin
                head <= head + PTR_W'(1);
            end
            count <= count + CNT_W'(fetch_c) - CNT_W'(pop_c);
        end
    end

    // Queue storage, cleared on reset so the outputs never carry X.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                q_pc[i]    <= '0;
                q_instr[i] <= '0;
            end
        end else if (fetch_c) begin
            q_pc[tail]    <= pc;
            q_instr[tail] <= icache_instr;
        end
    end

    // Outputs are decoded straight from registered state.
    always_comb begin
        icache_addr = pc;
        out_valid   = (count != '0);
        out_pc      = q_pc[head];
        out_instr   = q_instr[head];
        halted      = (state == ST_HALT) & (count == '0);
    end

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: memory model word i = 0x1000_0000 + i,
// expected PCs queued per scenario and checked as decode accepts them.
module tb_fetch_controller;

    logic        clk;
    logic        reset;
    logic [31:0] icache_addr;
    logic [31:0] icache_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halted;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [31:0] exp_q [$];

    fetch_controller #(
        .DEPTH     (4),
        .RESET_PC  (32'h0000_0000),
        .MEM_WORDS (552)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .icache_addr    (icache_addr),
        .icache_instr   (icache_instr),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted)
    );

    // Instruction memory model.
    assign icache_instr = 32'h1000_0000 + (icache_addr >> 2);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_seq(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(i * 4));
    endtask

    // Score any accepted head, then advance to just after the next edge.
    task automatic tick();
        logic [31:0] e;
        if (out_valid && out_ready) begin
            check("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("out_pc", out_pc, e);
                check("out_instr", out_instr, 32'h1000_0000 + (e >> 2));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic ready);
        reset = 1'b0;
        exp_q.delete();
        out_ready = ready;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        tick();
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        out_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_icache_addr", icache_addr, 32'h0);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_out_instr", out_instr, 32'h0);

        // Streaming from reset with no bubbles.
        @(posedge clk);
        #1;
        reset = 1'b1;
        push_seq(32'h0, 16);
        tick();
        check("first_valid", 32'(out_valid), 32'd1);
        check("first_pc", out_pc, 32'h0);
        check("first_instr", out_instr, 32'h1000_0000);
        for (int i = 0; i < 7; i++) begin
            tick();
            check("stream_valid", 32'(out_valid), 32'd1);
            check("stream_pc", out_pc, 32'(4 * (i + 1)));
        end

        // Backpressure fills the queue, then steady full-queue flow.
        do_reset(1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 3) check("bp_addr_full", icache_addr, 32'd16);
        end
        check("bp_addr_hold", icache_addr, 32'd16);
        check("bp_pc_hold", out_pc, 32'h0);
        check("bp_valid", 32'(out_valid), 32'd1);
        push_seq(32'h0, 20);
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check("full_addr", icache_addr, 32'(16 + 4 * i));
            check("full_head_pc", out_pc, 32'(4 * i));
        end

        // Redirect with three entries queued.
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0103;
        tick();
        check("redir_valid", 32'(out_valid), 32'd0);
        check("redir_addr", icache_addr, 32'h100);
        exp_q.delete();
        push_seq(32'h100, 8);
        redirect_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("redir_first_valid", 32'(out_valid), 32'd1);
        check("redir_first_pc", out_pc, 32'h100);
        check("redir_first_instr", out_instr, 32'h1000_0040);
        for (int i = 0; i < 3; i++) tick();

        // End of memory: fetch the last two words, then halt.
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0898;
        tick();
        exp_q.delete();
        push_seq(32'h898, 2);
        redirect_valid = 1'b0;
        tick();
        check("eom_first_pc", out_pc, 32'h898);
        tick();
        check("eom_addr_last", icache_addr, 32'h89C);
        check("eom_not_halted", 32'(halted), 32'd0);
        tick();
        check("eom_halted", 32'(halted), 32'd1);
        check("eom_empty", 32'(out_valid), 32'd0);
        for (int i = 0; i < 3; i++) tick();
        check("eom_addr_hold", icache_addr, 32'h89C);
        check("eom_still_halted", 32'(halted), 32'd1);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        // Redirect out of HALT resumes fetching.
        redirect_valid = 1'b1;
        redirect_pc = 32'h0;
        tick();
        check("resume_halted", 32'(halted), 32'd0);
        push_seq(32'h0, 2);
        redirect_valid = 1'b0;
        tick();
        check("resume_valid", 32'(out_valid), 32'd1);
        check("resume_pc", out_pc, 32'h0);

        // Redirect beyond memory halts without fetching.
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_1000;
        tick();
        exp_q.delete();
        redirect_valid = 1'b0;
        check("oob_addr", icache_addr, 32'h1000);
        check("oob_not_yet_halted", 32'(halted), 32'd0);
        tick();
        check("oob_halted", 32'(halted), 32'd1);
        check("oob_no_fetch", 32'(out_valid), 32'd0);
        tick();
        check("oob_addr_hold", icache_addr, 32'h1000);

        // Asynchronous reset between edges with two entries queued.
        do_reset(1'b0);
        tick();
        tick();
        check("async_pre_valid", 32'(out_valid), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("async_valid", 32'(out_valid), 32'd0);
        check("async_halted", 32'(halted), 32'd0);
        check("async_addr", icache_addr, 32'h0);
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;
        out_ready = 1'b1;
        push_seq(32'h0, 4);
        tick();
        check("async_restart_valid", 32'(out_valid), 32'd1);
        check("async_restart_pc", out_pc, 32'h0);
        for (int i = 0; i < 3; i++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
- Sequences the combinational-read instruction cache.
- Owns the PC, drives the cache address, and captures {pc, instruction} pairs into a DEPTH-entry fetch queue.
- Presents queued instructions to decode over a valid/ready handshake.
- Handles backend redirects (branch/jump/mispredict) by flushing and refetching, and halts when the PC runs past the end of instruction memory.

Parameters:
- DEPTH, 4, fetch-queue entries; must be a power of two, ≥2.
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- MEM_WORDS, 552, number of 32-bit words in instruction memory; the last fetchable address is (MEM_WORDS-1)*4.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- icache_addr  output  32  byte address to the cache; combinationally equal to the PC register.
- icache_instr  input  32  instruction word returned combinationally for icache_addr.
- out_valid  output  1  queue head holds a valid instruction.
- out_ready  input  1  decode accepts the head this cycle.
- out_instr  output  32  head instruction.
- out_pc  output  32  head PC.
- redirect_valid  input  1  flush the queue and restart fetch at redirect_pc.
- redirect_pc  input  32  redirect target; bits [1:0] are forced to 0.
- halted  output  1  fetch has stopped and the queue is empty.

Behaviour:
- Reset (reset=0, takes effect immediately, independent of clk):
  - pc=RESET_PC, head=tail=count=0, state=RUN.
  - out_valid=0, halted=0, icache_addr=RESET_PC; out_instr/out_pc=0.
  - Reset mid-operation discards all queue contents.
- State is RUN or HALT.
- pop = out_valid & out_ready.
- fetch = (state==RUN) & ~redirect_valid & (count<DEPTH | pop).
  - A full queue therefore accepts a new entry in the same cycle as a pop.
- On fetch:
  - Write {pc, icache_instr} at tail; tail++ (wraps mod DEPTH).
  - If pc == (MEM_WORDS-1)*4: state<=HALT and pc is held. Otherwise pc<=pc+4.
- count update: count<=count + fetch - pop. Simultaneous fetch and pop on a full queue leaves count=DEPTH; on an empty queue pop cannot occur.
- Latency: the instruction fetched at edge N is visible on out_valid/out_instr/out_pc after edge N (same-cycle cache read, one register stage).
- Redirect (redirect_valid=1 at an edge; highest priority after reset):
  - head=tail=count=0.
  - pc<={redirect_pc[31:2],2'b00}.
  - state<=RUN, including from HALT.
  - No enqueue that cycle. A coincident pop is discarded with the flush; the consumer accepted the old head, and the backend owns that ordering.
  - out_valid=0 in the cycle after the redirect edge; the first refetched instruction is valid one cycle later.
- A redirect to an address ≥ MEM_WORDS*4 goes to HALT at the next edge without fetching; the queue is empty, so halted=1.
- HALT: no fetches. The queue keeps draining through pops. halted = (state==HALT) & (count==0), registered-state derived with no combinational path from out_ready.
- Outputs out_valid=(count!=0), out_instr/out_pc = entry[head]. Values are unchanged while out_valid=1 & out_ready=0.
- No X propagation: queue storage is reset to 0.

Test Plan:
- Reset release, RESET_PC=0, out_ready=1, memory word i = 32'h1000_0000+i:
  - Edge 1 → out_valid=1, out_pc=0, out_instr=32'h1000_0000.
  - Each subsequent edge advances out_pc by 4 with no bubbles.
- Backpressure, out_ready=0 for 10 cycles:
  - Queue fills after 4 edges; icache_addr holds at 16; out_pc stays 0.
  - Release out_ready → pcs 0,4,8,12,16,... in order, none dropped or duplicated.
- Full queue with out_ready=1 steady:
  - Count stays 4 and one entry enters and one leaves per cycle (simultaneous fetch/pop on full).
- Redirect, redirect_valid=1 with redirect_pc=32'h0000_0103 while 3 entries are queued:
  - Next cycle out_valid=0, icache_addr=32'h100.
  - Following cycle out_pc=32'h100 with its memory word.
- End of memory, redirect to (MEM_WORDS-2)*4=32'h898:
  - Fetches 32'h898 and 32'h89C, then stops; icache_addr holds 32'h89C.
  - halted=1 once both are popped.
  - A redirect to 0 then resumes fetch and clears halted.
- Async reset asserted mid-stream (between clock edges, 2 entries queued):
  - out_valid and halted go 0 and icache_addr goes to RESET_PC immediately, without waiting for a clock edge.
  - After release, fetch restarts from RESET_PC.
